// File: rtl/ahb_ap_ctrl_if.sv
// Bundle of the fifo1/fifo2 handshakes, the AHB-Lite master bus and status flags
// that surround the MEM-AP controller.
interface ahb_ap_ctrl_if;
  logic        rempty;
  logic [40:0] rdata_fifo1;
  logic        rinc;
  logic        wfull;
  logic [31:0] wdata_fifo2;
  logic        winc;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        busy;
  logic        sticky_err;

  modport master (
    input  rempty, rdata_fifo1, wfull, HRDATA, HREADY, HRESP,
    output rinc, wdata_fifo2, winc, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
           busy, sticky_err
  );

  modport slave (
    output rempty, rdata_fifo1, wfull, HRDATA, HREADY, HRESP,
    input  rinc, wdata_fifo2, winc, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
           busy, sticky_err
  );
endinterface

// File: rtl/ahb_ap_ctrl.sv
// MEM-AP controller: decodes one debug command at a time into CSW/TAR/DRW/IDR
// accesses, runs single AHB-Lite transfers for DRW and returns read data via fifo2.
module ahb_ap_ctrl #(
  parameter logic [31:0] CSW_RESET = 32'h0000_0002,
  parameter logic [31:0] AP_IDR    = 32'h0477_0001
) (
  input logic           CLK,
  input logic           nRST,
  ahb_ap_ctrl_if.master bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXEC = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_PUSH = 3'd4;

  localparam logic [7:0] A_CSW = 8'h00;
  localparam logic [7:0] A_TAR = 8'h04;
  localparam logic [7:0] A_DRW = 8'h0C;
  localparam logic [7:0] A_IDR = 8'hFC;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  logic [2:0]  state_r;
  logic [40:0] cmd_r;
  logic [7:0]  csw_r;
  logic [31:0] tar_r;
  logic [31:0] result_r;
  logic [31:0] haddr_r;
  logic        hwrite_r;
  logic [2:0]  hsize_r;
  logic [1:0]  htrans_r;
  logic [31:0] hwdata_r;

  logic        cmd_wnr_s;
  logic [7:0]  cmd_addr_s;
  logic [31:0] cmd_data_s;

  assign cmd_wnr_s  = cmd_r[40];
  assign cmd_addr_s = cmd_r[39:32];
  assign cmd_data_s = cmd_r[31:0];

  // Sizes above word are not supported by this AP and fall back to word.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    logic [2:0] res;
    if (size > 3'd2) begin
      res = 3'b010;
    end else begin
      res = size;
    end
    return res;
  endfunction

  // Controller FSM, AP registers and registered AHB/response outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= ST_IDLE;
      cmd_r    <= 41'd0;
      csw_r    <= CSW_RESET[7:0];
      tar_r    <= 32'd0;
      result_r <= 32'd0;
      haddr_r  <= 32'd0;
      hwrite_r <= 1'b0;
      hsize_r  <= 3'd0;
      htrans_r <= HT_IDLE;
      hwdata_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!bus.rempty) begin
            cmd_r   <= bus.rdata_fifo1;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cmd_addr_s)
            A_CSW: begin
              if (cmd_wnr_s) begin
                csw_r[5:4] <= cmd_data_s[5:4];
                csw_r[2:0] <= cmd_data_s[2:0];
                if (cmd_data_s[7]) begin
                  csw_r[7] <= 1'b0;
                end
                state_r <= ST_IDLE;
              end else begin
                result_r <= {24'd0, csw_r[7], 1'b0, csw_r[5:0]};
                state_r  <= ST_PUSH;
              end
            end
            A_TAR: begin
              if (cmd_wnr_s) begin
                tar_r   <= cmd_data_s;
                state_r <= ST_IDLE;
              end else begin
                result_r <= tar_r;
                state_r  <= ST_PUSH;
              end
            end
            A_DRW: begin
              haddr_r  <= tar_r;
              hwrite_r <= cmd_wnr_s;
              hsize_r  <= clamp_size(csw_r[2:0]);
              htrans_r <= HT_NONSEQ;
              state_r  <= ST_ADDR;
            end
            A_IDR: begin
              if (cmd_wnr_s) begin
                state_r <= ST_IDLE;
              end else begin
                result_r <= AP_IDR;
                state_r  <= ST_PUSH;
              end
            end
            default: begin
              if (cmd_wnr_s) begin
                state_r <= ST_IDLE;
              end else begin
                result_r <= 32'd0;
                state_r  <= ST_PUSH;
              end
            end
          endcase
        end
        ST_ADDR: begin
          if (bus.HREADY) begin
            htrans_r <= HT_IDLE;
            if (hwrite_r) begin
              hwdata_r <= cmd_data_s;
            end
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.HREADY) begin
            if (bus.HRESP) begin
              csw_r[7] <= 1'b1;
              if (hwrite_r) begin
                state_r <= ST_IDLE;
              end else begin
                result_r <= 32'd0;
                state_r  <= ST_PUSH;
              end
            end else begin
              if (csw_r[5:4] == 2'b01) begin
                tar_r <= tar_r + (32'd1 << hsize_r);
              end
              if (hwrite_r) begin
                state_r <= ST_IDLE;
              end else begin
                result_r <= bus.HRDATA;
                state_r  <= ST_PUSH;
              end
            end
          end
        end
        ST_PUSH: begin
          if (!bus.wfull) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // The FIFO strobes must follow rempty/wfull in the same cycle, otherwise a
  // pop or push could land on an empty/full FIFO; they decode from state_r.
  assign bus.rinc        = (state_r == ST_IDLE) && !bus.rempty;
  assign bus.winc        = (state_r == ST_PUSH) && !bus.wfull;
  assign bus.wdata_fifo2 = result_r;
  assign bus.HADDR       = haddr_r;
  assign bus.HWRITE      = hwrite_r;
  assign bus.HSIZE       = hsize_r;
  assign bus.HTRANS      = htrans_r;
  assign bus.HWDATA      = hwdata_r;
  assign bus.busy        = (state_r != ST_IDLE);
  assign bus.sticky_err  = csw_r[7];

endmodule

// File: tb/tb_ahb_ap_ctrl.sv
// Directed self-checking bench for ahb_ap_ctrl: fifo1/fifo2 and the AHB slave
// are modelled by the stimulus sequence itself.
module tb_ahb_ap_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  int          pushes;
  logic [31:0] push_data;
  logic [31:0] seen_addr;
  logic [2:0]  seen_size;

  ahb_ap_ctrl_if bus();

  ahb_ap_ctrl #(.CSW_RESET(32'h0000_0002), .AP_IDR(32'h0477_0001)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one command on fifo1 and wait (bounded) for the controller to pop it.
  task automatic push_cmd(input logic wnr, input logic [7:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    @(negedge clk);
    bus.rdata_fifo1 = {wnr, addr, data};
    bus.rempty      = 1'b0;
    #1;
    while (!bus.rinc && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("pop", bus.rinc, 32'd1);
    @(posedge clk);
    #1;
    bus.rempty = 1'b1;
  endtask

  task automatic run_idle();
    int n;
    n         = 0;
    pushes    = 0;
    push_data = 32'hXXXX_XXXX;
    seen_addr = 32'h5555_5555;
    seen_size = 3'b111;
    do begin
      @(negedge clk);
      if (bus.HTRANS == 2'b10) begin
        seen_addr = bus.HADDR;
        seen_size = bus.HSIZE;
      end
      if (bus.winc) begin
        pushes++;
        push_data = bus.wdata_fifo2;
      end
      n++;
    end while (bus.busy && n < 50);
    chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    push_cmd(1'b0, addr, 32'd0);
    run_idle();
    chk({tag, "_npush"}, pushes, 32'd1);
    chk({tag, "_data"}, push_data, exp);
  endtask

  task automatic do_write(input string tag, input logic [7:0] addr, input logic [31:0] data);
    push_cmd(1'b1, addr, data);
    run_idle();
    chk({tag, "_npush"}, pushes, 32'd0);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.rempty      = 1'b1;
    bus.rdata_fifo1 = 41'd0;
    bus.wfull       = 1'b0;
    bus.HRDATA      = 32'd0;
    bus.HREADY      = 1'b1;
    bus.HRESP       = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_htrans", bus.HTRANS, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_rinc", bus.rinc, 32'd0);
    chk("rst_winc", bus.winc, 32'd0);
    chk("rst_haddr", bus.HADDR, 32'd0);
    chk("rst_sticky", bus.sticky_err, 32'd0);
    rst_n = 1'b1;

    // Auto-incrementing word reads from 0x2000_0000.
    do_write("tar_wr", 8'h04, 32'h2000_0000);
    do_write("csw_wr", 8'h00, 32'h0000_0012);
    for (int i = 0; i < 3; i++) begin
      bus.HRDATA = 32'hA5A5_0001 + i;
      do_read("drw_rd", 8'h0C, 32'hA5A5_0001 + i);
      chk("drw_rd_haddr", seen_addr, 32'h2000_0000 + 32'd4 * i);
      chk("drw_rd_hsize", seen_size, 32'd2);
    end
    do_read("tar_rd1", 8'h04, 32'h2000_000C);

    // Write with three data-phase wait states.
    push_cmd(1'b1, 8'h0C, 32'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk);
    chk("ws_htrans_addr", bus.HTRANS, 32'd2);
    chk("ws_haddr", bus.HADDR, 32'h2000_000C);
    chk("ws_hwrite", bus.HWRITE, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.HREADY = (i == 3);
      chk("ws_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
      chk("ws_htrans_data", bus.HTRANS, 32'd0);
      chk("ws_winc", bus.winc, 32'd0);
      chk("ws_busy", bus.busy, 32'd1);
    end
    @(negedge clk);
    chk("ws_done", bus.busy, 32'd0);

    // Read completes while fifo2 is full; a next command waits meanwhile.
    bus.wfull  = 1'b1;
    bus.HRDATA = 32'h1234_5678;
    push_cmd(1'b0, 8'h0C, 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.rdata_fifo1 = {1'b0, 8'h04, 32'd0};
    bus.rempty      = 1'b0;
    #1;
    chk("wf_rinc_data", bus.rinc, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("wf_winc_held", bus.winc, 32'd0);
      chk("wf_rinc_held", bus.rinc, 32'd0);
    end
    @(negedge clk);
    bus.wfull = 1'b0;
    #1;
    chk("wf_winc", bus.winc, 32'd1);
    chk("wf_wdata", bus.wdata_fifo2, 32'h1234_5678);
    chk("wf_rinc_push", bus.rinc, 32'd0);
    @(negedge clk);
    #1;
    chk("wf_winc_once", bus.winc, 32'd0);
    chk("wf_pop_next", bus.rinc, 32'd1);
    @(posedge clk);
    #1;
    bus.rempty = 1'b1;
    run_idle();
    chk("tar_rd2_npush", pushes, 32'd1);
    chk("tar_rd2_data", push_data, 32'h2000_0014);

    // Error response on a read.
    bus.HRESP = 1'b1;
    do_read("err_rd", 8'h0C, 32'd0);
    bus.HRESP = 1'b0;
    chk("err_sticky", bus.sticky_err, 32'd1);
    do_read("err_tar", 8'h04, 32'h2000_0014);
    do_read("err_csw", 8'h00, 32'h0000_0092);
    do_write("clr_csw", 8'h00, 32'h0000_0092);
    chk("clr_sticky", bus.sticky_err, 32'd0);
    do_read("clr_csw_rd", 8'h00, 32'h0000_0012);

    // Size clamp with no auto-increment.
    do_write("clamp_csw", 8'h00, 32'h0000_0005);
    bus.HRDATA = 32'h0BAD_F00D;
    do_read("clamp_rd", 8'h0C, 32'h0BAD_F00D);
    chk("clamp_hsize", seen_size, 32'd2);
    do_read("clamp_tar", 8'h04, 32'h2000_0014);

    // Halfword access wrapping the address space.
    do_write("wrap_tar", 8'h04, 32'hFFFF_FFFE);
    do_write("wrap_csw", 8'h00, 32'h0000_0011);
    do_write("wrap_wr", 8'h0C, 32'h0000_0001);
    chk("wrap_haddr0", seen_addr, 32'hFFFF_FFFE);
    chk("wrap_hsize0", seen_size, 32'd1);
    bus.HRDATA = 32'hCAFE_0000;
    do_read("wrap_rd", 8'h0C, 32'hCAFE_0000);
    chk("wrap_haddr1", seen_addr, 32'h0000_0000);
    chk("wrap_hsize1", seen_size, 32'd1);
    do_read("idr_rd", 8'hFC, 32'h0477_0001);
    do_read("unk_rd", 8'h20, 32'h0000_0000);

    // Reset in the middle of the address phase.
    push_cmd(1'b0, 8'h0C, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("mr_htrans_pre", bus.HTRANS, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mr_htrans", bus.HTRANS, 32'd0);
    chk("mr_busy", bus.busy, 32'd0);
    chk("mr_haddr", bus.HADDR, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_read("mr_csw", 8'h00, 32'h0000_0002);
    do_read("mr_tar", 8'h04, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
